// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: states, instruction
// classes, datapath mux/ALU codes, opcode patterns and the control bundle.
package legv8_ctrl_pkg;

  localparam int unsigned OP_W = 11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_LDUR = 3'd3,
    CLS_STUR = 3'd4,
    CLS_CBZ  = 3'd5,
    CLS_CBNZ = 3'd6,
    CLS_B    = 3'd7
  } cls_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;

  // Pattern/mask pairs: a mask bit of 0 marks a don't-care opcode bit.
  localparam logic [OP_W-1:0] OP_ADD   = 11'b10001011000;
  localparam logic [OP_W-1:0] OP_SUB   = 11'b11001011000;
  localparam logic [OP_W-1:0] OP_AND   = 11'b10001010000;
  localparam logic [OP_W-1:0] OP_ORR   = 11'b10101010000;
  localparam logic [OP_W-1:0] OP_ADDI  = 11'b10010001000;
  localparam logic [OP_W-1:0] OP_SUBI  = 11'b11010001000;
  localparam logic [OP_W-1:0] OP_LDUR  = 11'b11111000010;
  localparam logic [OP_W-1:0] OP_STUR  = 11'b11111000000;
  localparam logic [OP_W-1:0] OP_CBZ   = 11'b10110100000;
  localparam logic [OP_W-1:0] OP_CBNZ  = 11'b10110101000;
  localparam logic [OP_W-1:0] OP_B     = 11'b00010100000;

  localparam logic [OP_W-1:0] MASK_FULL = 11'b11111111111;
  localparam logic [OP_W-1:0] MASK_IMM  = 11'b11111111110;
  localparam logic [OP_W-1:0] MASK_CB   = 11'b11111111000;
  localparam logic [OP_W-1:0] MASK_B    = 11'b11111100000;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg2loc;
    logic       alu_src_a;
    logic       mem_to_reg;
    logic       fault;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_match(input logic [OP_W-1:0] op,
                                    input logic [OP_W-1:0] pat,
                                    input logic [OP_W-1:0] mask);
    return ((op ^ pat) & mask) == '0;
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational classifier: maps the top 11 opcode bits to an instruction class.
module opcode_class_decode
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 11
) (
  input  logic [OPW-1:0] opcode,
  output cls_e           cls_c
);

  logic [OP_W-1:0] op;

  assign op = opcode[OPW-1 -: OP_W];

  always_comb begin
    cls_c = CLS_NONE;
    if (op_match(op, OP_ADD, MASK_FULL) || op_match(op, OP_SUB, MASK_FULL) ||
        op_match(op, OP_AND, MASK_FULL) || op_match(op, OP_ORR, MASK_FULL)) begin
      cls_c = CLS_R;
    end else if (op_match(op, OP_ADDI, MASK_IMM) || op_match(op, OP_SUBI, MASK_IMM)) begin
      cls_c = CLS_I;
    end else if (op_match(op, OP_LDUR, MASK_FULL)) begin
      cls_c = CLS_LDUR;
    end else if (op_match(op, OP_STUR, MASK_FULL)) begin
      cls_c = CLS_STUR;
    end else if (op_match(op, OP_CBZ, MASK_CB)) begin
      cls_c = CLS_CBZ;
    end else if (op_match(op, OP_CBNZ, MASK_CB)) begin
      cls_c = CLS_CBNZ;
    end else if (op_match(op, OP_B, MASK_B)) begin
      cls_c = CLS_B;
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// LEGv8 multi-cycle control FSM with memory-wait timeout and sticky fault.
module multi_cycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 11,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           Reset_L,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           IRWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           Reg2Loc,
  output logic           ALUSrcA,
  output logic           MemToReg,
  output logic           Fault,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSrc,
  output logic [1:0]     ALUOp,
  output logic [2:0]     State
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;
  ctrl_t            ctrl_c;

  opcode_class_decode #(.OPW(OPW)) u_decode (
    .opcode (Opcode),
    .cls_c  (dec_cls_c)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  // This waiting cycle is the TIMEOUT-th one; MemReady is checked first so ready wins.
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = '0;
    ctrl_c  = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        if (MemReady) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = ST_DECODE;
        end else if (timeout_c) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        cls_d = dec_cls_c;
        case (dec_cls_c)
          CLS_R, CLS_I, CLS_LDUR, CLS_STUR: state_d = ST_EXEC;
          CLS_CBZ, CLS_CBNZ, CLS_B:         state_d = ST_BRANCH;
          default:                          state_d = ST_FAULT;
        endcase
      end
      ST_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        case (cls_q)
          CLS_R: begin
            ctrl_c.alu_src_b = SRCB_REG;
            ctrl_c.alu_op    = ALUOP_FUNCT;
            state_d          = ST_WB;
          end
          CLS_I: begin
            ctrl_c.alu_src_b = SRCB_IMM;
            ctrl_c.alu_op    = ALUOP_FUNCT;
            state_d          = ST_WB;
          end
          CLS_LDUR, CLS_STUR: begin
            ctrl_c.alu_src_b = SRCB_IMM;
            ctrl_c.alu_op    = ALUOP_ADD;
            state_d          = ST_MEM;
          end
          default: state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        if (cls_q == CLS_LDUR) begin
          ctrl_c.mem_read = 1'b1;
        end else if (cls_q == CLS_STUR) begin
          ctrl_c.mem_write = 1'b1;
          ctrl_c.reg2loc   = 1'b1;
        end
        if ((cls_q != CLS_LDUR) && (cls_q != CLS_STUR)) begin
          state_d = ST_FAULT;
        end else if (MemReady) begin
          state_d = (cls_q == CLS_LDUR) ? ST_WB : ST_FETCH;
        end else if (timeout_c) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = (cls_q == CLS_LDUR);
        state_d           = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl_c.reg2loc = 1'b1;
        ctrl_c.alu_op  = ALUOP_PASSB;
        ctrl_c.pc_src  = PCSRC_BR;
        case (cls_q)
          CLS_CBZ:  ctrl_c.pc_write = Zero;
          CLS_CBNZ: ctrl_c.pc_write = ~Zero;
          CLS_B:    ctrl_c.pc_write = 1'b1;
          default:  ctrl_c.pc_write = 1'b0;
        endcase
        state_d = ST_FETCH;
      end
      default: begin
        ctrl_c.fault = 1'b1;
        state_d      = ST_FAULT;
      end
    endcase
    // Outputs decode from state plus live inputs, so reset must mask them directly.
    if (!Reset_L) begin
      ctrl_c = '0;
    end
  end

  assign PCWrite  = ctrl_c.pc_write;
  assign IRWrite  = ctrl_c.ir_write;
  assign MemRead  = ctrl_c.mem_read;
  assign MemWrite = ctrl_c.mem_write;
  assign RegWrite = ctrl_c.reg_write;
  assign Reg2Loc  = ctrl_c.reg2loc;
  assign ALUSrcA  = ctrl_c.alu_src_a;
  assign MemToReg = ctrl_c.mem_to_reg;
  assign Fault    = ctrl_c.fault;
  assign ALUSrcB  = ctrl_c.alu_src_b;
  assign PCSrc    = ctrl_c.pc_src;
  assign ALUOp    = ctrl_c.alu_op;
  assign State    = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle vector table plus corner sequences.
module tb_multi_cycle_control;

  logic        CLK;
  logic        Reset_L;
  logic [10:0] Opcode;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Reg2Loc;
  logic        ALUSrcA, MemToReg, Fault;
  logic [1:0]  ALUSrcB, PCSrc, ALUOp;
  logic [2:0]  State;

  multi_cycle_control dut (
    .CLK      (CLK),
    .Reset_L  (Reset_L),
    .Opcode   (Opcode),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .Reg2Loc  (Reg2Loc),
    .ALUSrcA  (ALUSrcA),
    .MemToReg (MemToReg),
    .Fault    (Fault),
    .ALUSrcB  (ALUSrcB),
    .PCSrc    (PCSrc),
    .ALUOp    (ALUOp),
    .State    (State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] ADDI = 11'b10010001000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100000;
  localparam logic [10:0] CBNZ = 11'b10110101000;
  localparam logic [10:0] BR   = 11'b00010100000;
  localparam logic [10:0] BAD  = 11'b00000000000;

  // Observed bundle: State, then enables, then ALUSrcB, PCSrc, ALUOp.
  logic [17:0] got;
  assign got = {State, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Reg2Loc,
                ALUSrcA, MemToReg, Fault, ALUSrcB, PCSrc, ALUOp};

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [10:0] op;
    logic        zero;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  // en bit order: pcw irw mr | mw rw r2l | asa m2r flt
  function automatic logic [17:0] mk(input logic [2:0] st, input logic [8:0] en,
                                     input logic [1:0] srcb, input logic [1:0] pcsrc,
                                     input logic [1:0] aluop);
    return {st, en, srcb, pcsrc, aluop};
  endfunction

  task automatic chk(input string name, input logic [17:0] g, input logic [17:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b (t=%0t)", name, g, e, $time);
    end
  endtask

  task automatic drive(input logic [10:0] op, input logic z, input logic r);
    Opcode   = op;
    Zero     = z;
    MemReady = r;
    @(negedge CLK);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset_L  = 1'b0;
    MemReady = 1'b0;
    Opcode   = BAD;
    Zero     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    Reset_L = 1'b1;
  endtask

  function automatic void add(input string n, input logic [10:0] op, input logic z,
                              input logic r, input logic [17:0] e);
    vec_t v;
    v.name = n; v.op = op; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  logic [17:0] E_ZERO, E_F_RDY, E_F_WAIT, E_DEC, E_EX_R, E_EX_I, E_EX_M;
  logic [17:0] E_MEM_LD, E_MEM_ST, E_WB, E_WB_LD, E_BR0, E_BR1, E_FAULT;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    E_ZERO   = mk(3'd0, 9'b000_000_000, 2'b00, 2'b00, 2'b00);
    E_F_RDY  = mk(3'd0, 9'b111_000_000, 2'b01, 2'b00, 2'b00);
    E_F_WAIT = mk(3'd0, 9'b001_000_000, 2'b01, 2'b00, 2'b00);
    E_DEC    = mk(3'd1, 9'b000_000_000, 2'b00, 2'b00, 2'b00);
    E_EX_R   = mk(3'd2, 9'b000_000_100, 2'b00, 2'b00, 2'b10);
    E_EX_I   = mk(3'd2, 9'b000_000_100, 2'b10, 2'b00, 2'b10);
    E_EX_M   = mk(3'd2, 9'b000_000_100, 2'b10, 2'b00, 2'b00);
    E_MEM_LD = mk(3'd3, 9'b001_000_000, 2'b00, 2'b00, 2'b00);
    E_MEM_ST = mk(3'd3, 9'b000_101_000, 2'b00, 2'b00, 2'b00);
    E_WB     = mk(3'd4, 9'b000_010_000, 2'b00, 2'b00, 2'b00);
    E_WB_LD  = mk(3'd4, 9'b000_010_010, 2'b00, 2'b00, 2'b00);
    E_BR0    = mk(3'd5, 9'b000_001_000, 2'b00, 2'b01, 2'b01);
    E_BR1    = mk(3'd5, 9'b100_001_000, 2'b00, 2'b01, 2'b01);
    E_FAULT  = mk(3'd6, 9'b000_000_001, 2'b00, 2'b00, 2'b00);

    // ADD: opcode is scrambled during EXEC; the latched class must still finish it.
    add("add_fetch",  ADD,  1'b0, 1'b1, E_F_RDY);
    add("add_dec",    ADD,  1'b0, 1'b1, E_DEC);
    add("add_exec",   BAD,  1'b0, 1'b1, E_EX_R);
    add("add_wb",     BAD,  1'b0, 1'b1, E_WB);
    add("ld_fetch",   LDUR, 1'b0, 1'b1, E_F_RDY);
    add("ld_dec",     LDUR, 1'b0, 1'b1, E_DEC);
    add("ld_exec",    LDUR, 1'b0, 1'b1, E_EX_M);
    add("ld_mem1",    LDUR, 1'b0, 1'b0, E_MEM_LD);
    add("ld_mem2",    LDUR, 1'b0, 1'b0, E_MEM_LD);
    add("ld_mem3",    LDUR, 1'b0, 1'b0, E_MEM_LD);
    add("ld_mem4",    LDUR, 1'b0, 1'b1, E_MEM_LD);
    add("ld_wb",      LDUR, 1'b0, 1'b1, E_WB_LD);
    add("cbz_fetch",  CBZ,  1'b0, 1'b1, E_F_RDY);
    add("cbz_dec",    CBZ,  1'b0, 1'b1, E_DEC);
    add("cbz_z0_br",  CBZ,  1'b0, 1'b1, E_BR0);
    add("cbnz_fetch", CBNZ, 1'b0, 1'b1, E_F_RDY);
    add("cbnz_dec",   CBNZ, 1'b0, 1'b1, E_DEC);
    add("cbnz_z0_br", CBNZ, 1'b0, 1'b1, E_BR1);
    add("b_fetch",    BR,   1'b0, 1'b1, E_F_RDY);
    add("b_dec",      BR,   1'b0, 1'b1, E_DEC);
    add("b_br",       BR,   1'b0, 1'b1, E_BR1);
    add("cbz2_fetch", CBZ,  1'b1, 1'b1, E_F_RDY);
    add("cbz2_dec",   CBZ,  1'b1, 1'b1, E_DEC);
    add("cbz_z1_br",  CBZ,  1'b1, 1'b1, E_BR1);
    add("addi_fetch", ADDI, 1'b0, 1'b1, E_F_RDY);
    add("addi_dec",   ADDI, 1'b0, 1'b1, E_DEC);
    add("addi_exec",  ADDI, 1'b0, 1'b1, E_EX_I);
    add("addi_wb",    ADDI, 1'b0, 1'b1, E_WB);
    add("st_fetch",   STUR, 1'b0, 1'b1, E_F_RDY);
    add("st_dec",     STUR, 1'b0, 1'b1, E_DEC);
    add("st_exec",    STUR, 1'b0, 1'b1, E_EX_M);
    add("st_mem",     STUR, 1'b0, 1'b1, E_MEM_ST);
    add("f_wait",     BAD,  1'b0, 1'b0, E_F_WAIT);
    add("bad_fetch",  BAD,  1'b0, 1'b1, E_F_RDY);
    add("bad_dec",    BAD,  1'b0, 1'b1, E_DEC);
    add("bad_fault",  ADD,  1'b0, 1'b1, E_FAULT);
    add("bad_sticky", ADD,  1'b0, 1'b1, E_FAULT);

    // Reset held with MemReady high: FETCH enables must stay masked.
    Reset_L = 1'b0; Opcode = ADD; Zero = 1'b0; MemReady = 1'b1;
    #1;
    chk("reset_t0", got, E_ZERO);
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_clocked", got, E_ZERO);
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].zero, vecs[i].rdy);
      chk(vecs[i].name, got, vecs[i].exp);
      tick();
    end

    // FETCH timeout: 15 waiting cycles then sticky FAULT.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      drive(ADD, 1'b0, 1'b0);
      if (i == 15) chk("fto_cycle15", got, E_F_WAIT);
      tick();
    end
    drive(ADD, 1'b0, 1'b1);
    chk("fto_fault", got, E_FAULT);
    repeat (3) tick();
    drive(ADD, 1'b0, 1'b1);
    chk("fto_sticky", got, E_FAULT);
    tick();

    // Ready arriving on the 15th FETCH cycle wins over the timeout.
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      drive(ADD, 1'b0, 1'b0);
      tick();
    end
    drive(ADD, 1'b0, 1'b1);
    chk("rdy15_fetch", got, E_F_RDY);
    tick();
    drive(ADD, 1'b0, 1'b1);
    chk("rdy15_decode", got, E_DEC);
    tick();

    // MEM timeout after a slow fetch: counter restarts on MEM entry.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(LDUR, 1'b0, 1'b0);
      tick();
    end
    drive(LDUR, 1'b0, 1'b1); tick();
    drive(LDUR, 1'b0, 1'b1); tick();
    drive(LDUR, 1'b0, 1'b1); tick();
    for (int i = 1; i <= 15; i++) begin
      drive(LDUR, 1'b0, 1'b0);
      if (i == 15) chk("mto_mem15", got, E_MEM_LD);
      tick();
    end
    drive(LDUR, 1'b0, 1'b1);
    chk("mto_fault", got, E_FAULT);
    tick();

    // Reset pulse mid-STUR MEM drops MemWrite without a clock edge.
    do_reset();
    drive(STUR, 1'b0, 1'b1); tick();
    drive(STUR, 1'b0, 1'b1); tick();
    drive(STUR, 1'b0, 1'b1); tick();
    drive(STUR, 1'b0, 1'b0);
    chk("st_mem_pre_reset", got, E_MEM_ST);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("st_async_reset", got, E_ZERO);
    Reset_L = 1'b1;
    tick();
    drive(STUR, 1'b0, 1'b0);
    chk("post_reset_fetch", got, E_F_WAIT);
    tick();
    drive(STUR, 1'b0, 1'b1);
    tick();
    drive(STUR, 1'b0, 1'b1);
    chk("post_reset_decode", got, E_DEC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
